// File: rtl/rr_arb_4_2_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package rr_arb_4_2_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_4_2_sel.sv
// Rotating priority encoder: first set bit of mask scanning upward from start, wrapping 3 -> 0.
module rr_sel_4
  import rr_arb_4_2_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to start wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (mask[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4_2.sv
// Four-requester round-robin arbiter with grant hold, optional forced rotation and encoded index.
module rr_arb_4_2
  import rr_arb_4_2_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   a,
  output logic               gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_REQ-1:0] other;
  logic [IDX_W-1:0]   idle_idx, next_idx;
  logic               idle_any, next_any;
  logic               preempt;

  // The register a doubles as the current owner while in GRANT.
  assign other   = req & ~onehot(a);
  assign preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && next_any;

  rr_sel_4 u_sel_idle (.mask(req),   .start(ptr),          .idx(idle_idx), .any(idle_any));
  rr_sel_4 u_sel_next (.mask(other), .start(a + 2'd1),     .idx(next_idx), .any(next_any));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      a         <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_any) begin
            a         <= idle_idx;
            gnt       <= onehot(idle_idx);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[a]) begin
            ptr      <= a + 2'd1;
            hold_cnt <= '0;
            if (next_any) begin
              a   <= next_idx;
              gnt <= onehot(next_idx);
            end else begin
              a         <= '0;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (preempt) begin
            ptr      <= a + 2'd1;
            a        <= next_idx;
            gnt      <= onehot(next_idx);
            hold_cnt <= '0;
          end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid   : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_encode  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt == onehot(a));
  // Only a release or a preempt may move the grant.
  a_stable  : assert property (@(posedge clk) disable iff (!rst_n)
                               (state == GRANT && req[a] && !preempt) |=> $stable(gnt));

endmodule
